// File: rtl/capture_system_pkg.sv
// Shared definitions for the capture path: packetizer state encoding and a
// constant-evaluable ceiling log2 used to size pointers and counters.
package capture_system_pkg;

  // Packetizer control states: normal streaming, or one-or-more flush cycles.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } cap_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/capture_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output. Pointers carry
// one extra wrap bit so full and empty are distinguished without a counter.
// A synchronous flush empties the FIFO and overrides push/pop that cycle.
module capture_sync_fifo
  import capture_system_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Push is refused when full even if a pop happens the same cycle.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Head entry is read combinationally so a word is visible the cycle after it is written.
  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state pointers: flush zeroes both, otherwise advance on accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  // Pointer registers, emptied asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/capture_packetizer.sv
// Buffers the gated capture stream and re-emits it in packets of at most
// BURST_LEN words, ending a packet early when an input word carried TLAST.
// Keeps running word/packet counts and pulses capture_done after the output
// of a word that closed an input frame. clear flushes buffer and counters.
module capture_packetizer
  import capture_system_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int BURST_LEN            = 16
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESETN,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  input  logic                              clear,
  output logic [31:0]                       word_count,
  output logic [31:0]                       pkt_count,
  output logic                              capture_done
);

  localparam int                BCW        = clog2(BURST_LEN) + 1;
  localparam logic [BCW-1:0]    BURST_LAST = BCW'(BURST_LEN - 1);
  localparam int                EW         = C_S_AXIS_TDATA_WIDTH + 1;

  cap_state_e       state_q, state_d;
  logic             ready_en_q;
  logic [BCW-1:0]   burst_q, burst_d;
  logic [31:0]      word_count_q, word_count_d;
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic             done_q, done_d;

  logic             run;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic             in_hs;
  logic             out_hs;
  logic             head_last;
  logic             out_last;
  logic [EW-1:0]    head_entry;
  logic             unused_tstrb;

  // Input byte strobes carry no information for this stream.
  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign run        = (state_q == RUN);
  // Flush on the clear cycle itself so a same-cycle handshake is discarded.
  assign fifo_flush = clear || !run;

  // ready_en_q holds TREADY low for the first cycle after reset release.
  assign S_AXIS_TREADY = !fifo_full && run && ready_en_q;
  assign M_AXIS_TVALID = !fifo_empty && run;
  assign in_hs         = S_AXIS_TVALID && S_AXIS_TREADY;
  assign out_hs        = M_AXIS_TVALID && M_AXIS_TREADY;

  assign head_last    = head_entry[0];
  assign M_AXIS_TDATA = head_entry[EW-1:1];
  assign out_last     = (burst_q == BURST_LAST) || head_last;
  assign M_AXIS_TLAST = out_last;
  assign M_AXIS_TSTRB = '1;

  assign word_count   = word_count_q;
  assign pkt_count    = pkt_count_q;
  assign capture_done = done_q;

  capture_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (S_AXIS_ACLK),
    .rst_n       (S_AXIS_ARESETN),
    .flush_i     (fifo_flush),
    .push_i      (in_hs),
    .push_data_i ({S_AXIS_TDATA, S_AXIS_TLAST}),
    .pop_i       (out_hs),
    .head_data_o (head_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Next state, packet position and counters; clear beats any handshake.
  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    word_count_d = word_count_q;
    pkt_count_d  = pkt_count_q;
    done_d       = 1'b0;
    case (state_q)
      RUN: begin
        if (clear) begin
          state_d      = FLUSH;
          burst_d      = '0;
          word_count_d = '0;
          pkt_count_d  = '0;
        end else begin
          if (in_hs) begin
            word_count_d = word_count_q + 32'd1;
          end
          if (out_hs) begin
            done_d = head_last;
            if (out_last) begin
              burst_d     = '0;
              pkt_count_d = pkt_count_q + 32'd1;
            end else begin
              burst_d = burst_q + BCW'(1);
            end
          end
        end
      end
      FLUSH: begin
        burst_d      = '0;
        word_count_d = '0;
        pkt_count_d  = '0;
        if (!clear) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State and counter registers with asynchronous reset to an idle RUN state.
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q      <= RUN;
      ready_en_q   <= 1'b0;
      burst_q      <= '0;
      word_count_q <= '0;
      pkt_count_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      burst_q      <= burst_d;
      word_count_q <= word_count_d;
      pkt_count_q  <= pkt_count_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_capture_packetizer.sv
module tb_capture_packetizer;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  s_tdata;
  logic [3:0]    s_tstrb;
  logic          s_tlast;
  logic          s_tvalid;
  logic          s_tready;
  logic [W-1:0]  m_tdata;
  logic [3:0]    m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          clr;
  logic [31:0]   wc_o;
  logic [31:0]   pc_o;
  logic          done_o;

  always #5 clk = ~clk;

  capture_packetizer #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .C_M_AXIS_TDATA_WIDTH (W),
    .FIFO_DEPTH           (DEPTH),
    .BURST_LEN            (BURST)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TSTRB   (s_tstrb),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TSTRB   (m_tstrb),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TREADY  (m_tready),
    .clear          (clr),
    .word_count     (wc_o),
    .pkt_count      (pc_o),
    .capture_done   (done_o)
  );

  // Reference model: buffered words in order, position inside the current packet.
  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } ent_t;

  ent_t        q[$];
  int          pos;
  logic [31:0] wc_m;
  logic [31:0] pc_m;
  logic        done_m;
  logic        flush_m;
  logic        ready_m;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int obs_in, obs_out, obs_tlast, obs_done;
  bit last_hs_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pos     = 0;
    wc_m    = '0;
    pc_m    = '0;
    done_m  = 1'b0;
    flush_m = 1'b0;
    ready_m = 1'b0;
  endtask

  task automatic clear_tallies();
    obs_in = 0; obs_out = 0; obs_tlast = 0; obs_done = 0;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    logic         exp_tv, exp_tr, exp_last, hs_in, hs_out, c_l, in_l;
    logic [W-1:0] in_d;
    ent_t         e;
    @(negedge clk);
    exp_tr   = ready_m && !flush_m && (q.size() < DEPTH);
    exp_tv   = !flush_m && (q.size() != 0);
    exp_last = 1'b0;
    chk("s_tready", s_tready, exp_tr);
    chk("m_tvalid", m_tvalid, exp_tv);
    chk("m_tstrb", m_tstrb, 4'hF);
    if (exp_tv) begin
      exp_last = q[0].l || (pos == BURST - 1);
      chk("m_tdata", m_tdata, q[0].d);
      chk("m_tlast", m_tlast, exp_last);
    end
    if (m_tvalid && m_tready) obs_out++;
    if (m_tvalid && m_tready && m_tlast) obs_tlast++;
    if (s_tvalid && s_tready) obs_in++;
    hs_in  = s_tvalid && exp_tr;
    hs_out = exp_tv && m_tready;
    c_l    = clr;
    in_d   = s_tdata;
    in_l   = s_tlast;
    @(posedge clk);
    #1;
    if (c_l) begin
      q.delete();
      pos = 0; wc_m = '0; pc_m = '0; done_m = 1'b0; flush_m = 1'b1;
    end else if (flush_m) begin
      flush_m = 1'b0; done_m = 1'b0;
    end else begin
      done_m = hs_out && q[0].l;
      if (hs_out) begin
        if (exp_last) begin
          pos  = 0;
          pc_m = pc_m + 32'd1;
        end else begin
          pos++;
        end
        void'(q.pop_front());
      end
      if (hs_in) begin
        e.d = in_d;
        e.l = in_l;
        q.push_back(e);
        wc_m = wc_m + 32'd1;
      end
    end
    ready_m = 1'b1;
    if (done_o === 1'b1) obs_done++;
    chk("word_count", wc_o, wc_m);
    chk("pkt_count", pc_o, pc_m);
    chk("capture_done", done_o, done_m);
    last_hs_in = hs_in && !c_l && !flush_m;
  endtask

  task automatic send(input int n, input bit last_final);
    int sent;
    int guard;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 400) begin
      s_tvalid = 1'b1;
      s_tdata  = $urandom;
      s_tlast  = last_final && (sent == n - 1);
      cycle();
      if (last_hs_in) sent++;
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("send_count", sent, n);
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    while (q.size() != 0 && guard < 100) begin
      cycle();
      guard++;
    end
    chk("drain_tvalid", m_tvalid, 1'b0);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    cycle();
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_s_tready"}, s_tready, 1'b0);
    chk({tag, "_m_tvalid"}, m_tvalid, 1'b0);
    chk({tag, "_word_count"}, wc_o, 32'd0);
    chk({tag, "_pkt_count"}, pc_o, 32'd0);
    chk({tag, "_done"}, done_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_tdata = '0; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b0; clr = 1'b0;
    model_reset();
    clear_tallies();
    @(posedge clk); #1;
    rst_checks("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 10 words, TLAST on the 10th, BURST_LEN=4: packets end at words 4, 8, 10.
    clear_tallies();
    m_tready = 1'b1;
    send(10, 1'b1);
    drain();
    cycle(); cycle();
    chk("A_tlast_count", obs_tlast, 3);
    chk("A_pkt_count", pc_o, 32'd3);
    chk("A_word_count", wc_o, 32'd10);
    chk("A_done_pulses", obs_done, 1);

    // Output stalled, 20 cycles of offered words: only DEPTH accepted.
    do_clear();
    clear_tallies();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = $urandom;
      cycle();
    end
    chk("B_accepts", obs_in, 16);
    chk("B_tready_full", s_tready, 1'b0);
    chk("B_word_count", wc_o, 32'd16);
    m_tready = 1'b1;
    send(4, 1'b0);
    drain();
    chk("B_out_total", obs_out, 20);

    // Continuous streaming: one word per cycle after the first.
    do_clear();
    clear_tallies();
    m_tready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = $urandom;
      cycle();
    end
    chk("C_in", obs_in, 31);
    chk("C_out", obs_out, 30);
    chk("C_occupancy_one", m_tvalid, 1'b1);
    drain();

    // Clear with 5 words buffered: nothing of them is ever emitted.
    do_clear();
    m_tready = 1'b0;
    send(5, 1'b0);
    clr = 1'b1;
    cycle();
    chk("D_tvalid_after_clear", m_tvalid, 1'b0);
    chk("D_word_count", wc_o, 32'd0);
    chk("D_pkt_count", pc_o, 32'd0);
    clr = 1'b0;
    clear_tallies();
    m_tready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("D_emitted", obs_out, 0);

    // Reset mid-packet (two words already emitted, one buffered).
    do_clear();
    m_tready = 1'b1;
    send(2, 1'b0);
    drain();
    m_tready = 1'b0;
    send(1, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_checks("E_rst_now");
    model_reset();
    @(posedge clk); #1;
    rst_checks("E_rst_held");
    rst_n = 1'b1;
    clear_tallies();
    m_tready = 1'b1;
    send(4, 1'b0);
    drain();
    chk("E_tlast_count", obs_tlast, 1);
    chk("E_pkt_count", pc_o, 32'd1);

    // Single-word frame.
    do_clear();
    clear_tallies();
    send(1, 1'b1);
    drain();
    cycle();
    chk("F_pkt_count", pc_o, 32'd1);
    chk("F_tlast_count", obs_tlast, 1);
    chk("F_done_pulses", obs_done, 1);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      s_tlast  = ($urandom_range(0, 7) == 0);
      m_tready = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 63) == 0);
      cycle();
    end
    clr     = 1'b0;
    s_tlast = 1'b0;
    cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
